// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register-specifier widths, forwarding
// mode selector, the scoreboard entry record and the source-match helper.
package hazard_scoreboard_pkg;

  localparam int unsigned DefaultRegAddrW = 5;
  // Scoreboard entries hold a fixed-width dest; narrower specifiers are zero-extended.
  localparam int unsigned MaxRegAddrW     = 8;

  typedef enum logic {
    FwdNone    = 1'b0,  // full RAW interlock against every tracked stage
    FwdLoadUse = 1'b1   // only load-use against the ID/EX entry
  } fwd_mode_e;

  typedef struct packed {
    logic                   valid;
    logic                   is_load;
    logic [MaxRegAddrW-1:0] dest;
  } sb_entry_t;

  // Register $0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic src_match(sb_entry_t entry, logic [MaxRegAddrW-1:0] src,
                                     logic uses_src);
    return entry.valid & (entry.dest != '0) & (entry.dest == src) & uses_src;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus. The master side (pipeline) presents the instruction in ID
// and the branch outcome; the slave side (hazard unit) returns PC/IF-ID/bubble/flush
// controls and the stall counter.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned RegAddrW = DefaultRegAddrW,
  parameter int unsigned CntW     = 16
);

  logic [RegAddrW-1:0] if_id_rs;
  logic [RegAddrW-1:0] if_id_rt;
  logic                if_id_uses_rs;
  logic                if_id_uses_rt;
  logic                id_reg_write;
  logic                id_mem_read;
  logic [RegAddrW-1:0] id_write_reg;
  logic                id_mul_div;
  logic                id_uses_hi_lo;
  logic                branch_taken;

  logic                pc_write;
  logic                if_id_write;
  logic                control_mux;
  logic                if_id_flush;
  logic [CntW-1:0]     stall_cycles;

  modport master (
    output if_id_rs, if_id_rt, if_id_uses_rs, if_id_uses_rt, id_reg_write, id_mem_read,
           id_write_reg, id_mul_div, id_uses_hi_lo, branch_taken,
    input  pc_write, if_id_write, control_mux, if_id_flush, stall_cycles
  );

  modport slave (
    input  if_id_rs, if_id_rt, if_id_uses_rs, if_id_uses_rt, id_reg_write, id_mem_read,
           id_write_reg, id_mul_div, id_uses_hi_lo, branch_taken,
    output pc_write, if_id_write, control_mux, if_id_flush, stall_cycles
  );

endinterface

// File: rtl/hazard_muldiv_busy.sv
// HI/LO busy interlock. A counter loads MuldivLat-1 when a mul/div issues and
// counts down to zero; any HI/LO user (mul/div or mfhi/mflo) in ID while it is
// non-zero raises the busy hazard.
// Ports: clk_i, rst_i (sync, active-high), issue_i (mul/div leaves ID this cycle),
//        needs_hilo_i (ID instruction touches HI/LO), busy_hazard_o.
module hazard_muldiv_busy #(
  parameter int unsigned MuldivLat = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue_i,
  input  logic needs_hilo_i,
  output logic busy_hazard_o
);

  localparam int unsigned BusyW = (MuldivLat > 1) ? $clog2(MuldivLat) : 1;
  localparam logic [BusyW-1:0] LoadVal = BusyW'(MuldivLat - 1);

  logic [BusyW-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (issue_i) begin
      busy_d = LoadVal;
    end else if (busy_q != '0) begin
      busy_d = busy_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_hazard_o = (busy_q != '0) & needs_hilo_i;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS pipeline. Tracks in-flight destinations of the
// TrackDepth stages after ID in a shifting scoreboard and stalls the ID instruction
// on RAW (all stages, or load-use only when forwarding) or on a busy HI/LO unit.
// A taken branch flushes IF/ID and bubbles ID/EX, overriding any stall.
// Ports: clk_i, rst_i (sync, active-high), bus (hazard_scoreboard_if.slave):
//        ID instruction fields + branch_taken in; pc_write, if_id_write,
//        control_mux, if_id_flush, stall_cycles out.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned RegAddrW   = DefaultRegAddrW,
  parameter int unsigned TrackDepth = 2,
  parameter fwd_mode_e   Forwarding = FwdNone,
  parameter int unsigned MuldivLat  = 4,
  parameter int unsigned CntW       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_scoreboard_if.slave bus
);

  sb_entry_t [TrackDepth-1:0] sb_q, sb_d;
  logic [CntW-1:0]            stall_cnt_q, stall_cnt_d;
  logic [MaxRegAddrW-1:0]     rs, rt;
  logic                       raw, busy_hazard, stall, flush, control_mux;

  assign rs = MaxRegAddrW'(bus.if_id_rs);
  assign rt = MaxRegAddrW'(bus.if_id_rt);

  always_comb begin
    raw = 1'b0;
    if (Forwarding == FwdNone) begin
      for (int i = 0; i < TrackDepth; i++) begin
        raw |= src_match(sb_q[i], rs, bus.if_id_uses_rs) |
               src_match(sb_q[i], rt, bus.if_id_uses_rt);
      end
    end else begin
      raw = sb_q[0].is_load & (src_match(sb_q[0], rs, bus.if_id_uses_rs) |
                               src_match(sb_q[0], rt, bus.if_id_uses_rt));
    end
  end

  hazard_muldiv_busy #(
    .MuldivLat(MuldivLat)
  ) u_muldiv_busy (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .issue_i      (bus.id_mul_div & control_mux),
    .needs_hilo_i (bus.id_mul_div | bus.id_uses_hi_lo),
    .busy_hazard_o(busy_hazard)
  );

  // Reset forces default controls even while the old state still shows a hazard.
  assign stall       = (raw | busy_hazard) & ~bus.branch_taken & ~rst_i;
  assign flush       = bus.branch_taken & ~rst_i;
  assign control_mux = ~stall & ~flush;

  assign bus.pc_write     = ~stall;
  assign bus.if_id_write  = ~stall;
  assign bus.control_mux  = control_mux;
  assign bus.if_id_flush  = flush;
  assign bus.stall_cycles = stall_cnt_q;

  // Stalled or wrong-path instructions enter ID/EX as a bubble.
  always_comb begin
    sb_d = sb_q;
    if (control_mux) begin
      sb_d[0] = '{valid:   bus.id_reg_write,
                  is_load: bus.id_mem_read,
                  dest:    MaxRegAddrW'(bus.id_write_reg)};
    end else begin
      sb_d[0] = '0;
    end
    for (int i = 1; i < TrackDepth; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // The oldest entry and some is_load bits are only shifted, never compared.
  logic unused_sb;
  assign unused_sb = ^sb_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int Lat   = 4;
  localparam int Depth = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs, rt, wd;
  logic       urs, urt, wr, ld, md, hilo, br, rst;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  hazard_scoreboard_if #(.RegAddrW(5), .CntW(16)) if_nf ();
  hazard_scoreboard_if #(.RegAddrW(5), .CntW(16)) if_f ();

  assign if_nf.if_id_rs = rs;        assign if_f.if_id_rs = rs;
  assign if_nf.if_id_rt = rt;        assign if_f.if_id_rt = rt;
  assign if_nf.if_id_uses_rs = urs;  assign if_f.if_id_uses_rs = urs;
  assign if_nf.if_id_uses_rt = urt;  assign if_f.if_id_uses_rt = urt;
  assign if_nf.id_reg_write = wr;    assign if_f.id_reg_write = wr;
  assign if_nf.id_mem_read = ld;     assign if_f.id_mem_read = ld;
  assign if_nf.id_write_reg = wd;    assign if_f.id_write_reg = wd;
  assign if_nf.id_mul_div = md;      assign if_f.id_mul_div = md;
  assign if_nf.id_uses_hi_lo = hilo; assign if_f.id_uses_hi_lo = hilo;
  assign if_nf.branch_taken = br;    assign if_f.branch_taken = br;

  hazard_scoreboard #(
    .RegAddrW(5), .TrackDepth(Depth), .Forwarding(FwdNone), .MuldivLat(Lat), .CntW(16)
  ) dut_nf (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (if_nf)
  );

  hazard_scoreboard #(
    .RegAddrW(5), .TrackDepth(Depth), .Forwarding(FwdLoadUse), .MuldivLat(Lat), .CntW(16)
  ) dut_f (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (if_f)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: a window of what issued into ID/EX over the last Depth cycles, the cycle
  // of the last mul/div issue, and a plain stall tally. Index 0 = no forwarding.
  typedef struct {bit wr; bit ld; int dest;} slot_t;
  slot_t win [2][Depth];
  int    last_md [2];
  int    m_cnt [2];
  int    cyc = 0;

  initial begin
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < Depth; k++) win[m][k] = '{wr: 1'b0, ld: 1'b0, dest: 0};
      last_md[m] = -100;
      m_cnt[m]   = 0;
    end
  end

  function automatic bit reads_reg(int d);
    return (d != 0) && ((urs && int'(rs) == d) || (urt && int'(rt) == d));
  endfunction

  function automatic bit model_stall(int m);
    bit raw = 1'b0;
    bit busy;
    if (m == 0) begin
      for (int k = 0; k < Depth; k++) if (win[m][k].wr && reads_reg(win[m][k].dest)) raw = 1'b1;
    end else begin
      raw = win[m][0].wr && win[m][0].ld && reads_reg(win[m][0].dest);
    end
    busy = ((cyc - last_md[m]) < Lat) && (md || hilo);
    return (raw || busy) && !br && !rst;
  endfunction

  task automatic cmp_mode(input int m, input logic pcw, input logic ifw, input logic cm,
                          input logic fl, input logic [15:0] sc, input bit es);
    bit ef;
    ef = br && !rst;
    check($sformatf("c%0d m%0d pc_write", cyc, m), int'(pcw), int'(!es));
    check($sformatf("c%0d m%0d if_id_write", cyc, m), int'(ifw), int'(!es));
    check($sformatf("c%0d m%0d control_mux", cyc, m), int'(cm), int'(!es && !ef));
    check($sformatf("c%0d m%0d if_id_flush", cyc, m), int'(fl), int'(ef));
    check($sformatf("c%0d m%0d stall_cycles", cyc, m), int'(sc), m_cnt[m]);
  endtask

  // Per-cycle compare against the model, then advance the model past the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit es [2];
      bit issued;
      for (int m = 0; m < 2; m++) es[m] = model_stall(m);
      cmp_mode(0, if_nf.pc_write, if_nf.if_id_write, if_nf.control_mux, if_nf.if_id_flush,
               if_nf.stall_cycles, es[0]);
      cmp_mode(1, if_f.pc_write, if_f.if_id_write, if_f.control_mux, if_f.if_id_flush,
               if_f.stall_cycles, es[1]);
      for (int m = 0; m < 2; m++) begin
        if (rst) begin
          for (int k = 0; k < Depth; k++) win[m][k] = '{wr: 1'b0, ld: 1'b0, dest: 0};
          last_md[m] = -100;
          m_cnt[m]   = 0;
        end else begin
          issued = !es[m] && !br;
          for (int k = Depth - 1; k > 0; k--) win[m][k] = win[m][k-1];
          win[m][0] = '{wr: wr && issued, ld: ld, dest: int'(wd)};
          if (issued && md) last_md[m] = cyc;
          if (es[m] && m_cnt[m] < 65535) m_cnt[m]++;
        end
      end
      cyc++;
    end
  end

  // One ID-stage cycle with hand-computed stall expectations for each DUT.
  task automatic step(input int rs_v, input int rt_v, input bit urs_v, input bit urt_v,
                      input bit wr_v, input bit ld_v, input int wd_v, input bit md_v,
                      input bit hilo_v, input bit br_v, input bit rst_v,
                      input bit s_nf, input bit s_f);
    rs = 5'(rs_v); rt = 5'(rt_v); urs = urs_v; urt = urt_v; wr = wr_v; ld = ld_v;
    wd = 5'(wd_v); md = md_v; hilo = hilo_v; br = br_v; rst = rst_v;
    @(negedge clk);
    check("lit nf pc_write", int'(if_nf.pc_write), int'(!s_nf));
    check("lit f pc_write", int'(if_f.pc_write), int'(!s_f));
    check("lit nf flush", int'(if_nf.if_id_flush), int'(br_v && !rst_v));
    check("lit f control_mux", int'(if_f.control_mux), int'(!s_f && !(br_v && !rst_v)));
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_cnt(input string name, input int nf, input int f);
    check({name, " nf stall_cycles"}, int'(if_nf.stall_cycles), nf);
    check({name, " f stall_cycles"}, int'(if_f.stall_cycles), f);
  endtask

  initial begin
    rs = '0; rt = '0; wd = '0;
    urs = 0; urt = 0; wr = 0; ld = 0; md = 0; hilo = 0; br = 0; rst = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    //   rs rt urs urt wr ld wd md hl br rst  nf f
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0);
    check_cnt("reset", 0, 0);

    // Load-use on Rs: lw $8 then add $10,$8
    step(0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0,   0, 0);
    step(8, 0, 1, 0, 1, 0, 10, 0, 0, 0, 0,  1, 1);
    step(8, 0, 1, 0, 1, 0, 10, 0, 0, 0, 0,  1, 0);
    step(8, 0, 1, 0, 1, 0, 10, 0, 0, 0, 0,  0, 0);
    nop(); nop();
    check_cnt("load-use", 2, 1);

    // ALU RAW on Rt: add $9 then reader of $9
    step(0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0,   0, 0);
    step(0, 9, 0, 1, 1, 0, 11, 0, 0, 0, 0,  1, 0);
    step(0, 9, 0, 1, 1, 0, 11, 0, 0, 0, 0,  1, 0);
    step(0, 9, 0, 1, 1, 0, 11, 0, 0, 0, 0,  0, 0);
    nop(); nop();
    check_cnt("alu raw", 4, 1);

    // $0 never creates a dependency
    step(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,   0, 0);
    step(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0);
    nop(); nop();
    check_cnt("reg0", 4, 1);

    // mult then mflo: three busy stalls; then mult followed by independent add
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0);
    step(0, 0, 0, 0, 1, 0, 12, 0, 1, 0, 0,  1, 1);
    step(0, 0, 0, 0, 1, 0, 12, 0, 1, 0, 0,  1, 1);
    step(0, 0, 0, 0, 1, 0, 12, 0, 1, 0, 0,  1, 1);
    step(0, 0, 0, 0, 1, 0, 12, 0, 1, 0, 0,  0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0);
    step(3, 0, 1, 0, 1, 0, 13, 0, 0, 0, 0,  0, 0);
    nop(); nop(); nop();
    check_cnt("muldiv", 7, 4);

    // Load-use coinciding with a taken branch; wrong-path mult must not start busy
    step(0, 0, 0, 0, 1, 1, 15, 0, 0, 0, 0,  0, 0);
    step(15, 0, 1, 0, 1, 0, 16, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 17, 0, 1, 0, 0,  0, 0);
    nop(); nop();
    check_cnt("branch", 7, 4);

    // Reset during a busy stall
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0);
    step(0, 0, 0, 0, 1, 0, 12, 0, 1, 0, 0,  1, 1);
    check_cnt("pre-reset", 8, 5);
    step(0, 0, 0, 0, 1, 0, 12, 0, 1, 0, 1,  0, 0);
    check_cnt("post-reset", 0, 0);
    step(0, 0, 0, 0, 1, 0, 12, 0, 1, 0, 0,  0, 0);
    nop();
    check_cnt("end", 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
